// File: rtl/conv_layer_mem_if.sv
// Layer-memory bus between the CONV engine (master) and the layer memory (slave).
// Strobes only, no back-pressure: cwr/crd are accepted on every rising edge they are high.
interface conv_layer_mem_if #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 12
);
  logic                  cwr;
  logic [ADDR_WIDTH-1:0] caddr_wr;
  logic [DATA_WIDTH-1:0] cdata_wr;
  logic                  crd;
  logic [ADDR_WIDTH-1:0] caddr_rd;
  logic [2:0]            csel;
  logic [DATA_WIDTH-1:0] cdata_rd;
  logic                  rd_valid;
  logic [4:0]            bank_full;
  logic                  err;

  modport master (
    output cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
    input  cdata_rd, rd_valid, bank_full, err
  );

  modport slave (
    input  cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
    output cdata_rd, rd_valid, bank_full, err
  );
endinterface

// File: rtl/conv_layer_mem.sv
// Five-bank layer memory for the CONV engine: one write + one read per cycle, fill tracking, sticky err.
// Optional macro CONV_MEM_BYPASS_EN: same-cycle read/write to one entry returns the new data (write-first).
module conv_layer_mem #(
   parameter int DATA_WIDTH = 20,
   parameter int ADDR_WIDTH = 12,
   parameter int L0_DEPTH   = 4096,
   parameter int L1_DEPTH   = 1024,
   parameter int L2_DEPTH   = 2048
) (
   input logic             clk,
   input logic             reset,
   conv_layer_mem_if.slave bus
);

   localparam int TOTAL     = 2 * L0_DEPTH + 2 * L1_DEPTH + L2_DEPTH;
   localparam int IDX_W     = $clog2(TOTAL);
   localparam int MAX_DEPTH = (L0_DEPTH > L1_DEPTH) ?
                              ((L0_DEPTH > L2_DEPTH) ? L0_DEPTH : L2_DEPTH) :
                              ((L1_DEPTH > L2_DEPTH) ? L1_DEPTH : L2_DEPTH);
   localparam int CNT_W     = $clog2(MAX_DEPTH) + 1;

   // Banks are packed back to back in one array; depth 0 marks an illegal select.
   function automatic int unsigned depth_of(input logic [2:0] sel);
      case (sel)
         3'd1, 3'd2: depth_of = L0_DEPTH;
         3'd3, 3'd4: depth_of = L1_DEPTH;
         3'd5:       depth_of = L2_DEPTH;
         default:    depth_of = 0;
      endcase
   endfunction

   function automatic int unsigned base_of(input logic [2:0] sel);
      case (sel)
         3'd2:    base_of = L0_DEPTH;
         3'd3:    base_of = 2 * L0_DEPTH;
         3'd4:    base_of = 2 * L0_DEPTH + L1_DEPTH;
         3'd5:    base_of = 2 * L0_DEPTH + 2 * L1_DEPTH;
         default: base_of = 0;
      endcase
   endfunction

   logic [DATA_WIDTH-1:0] mem [TOTAL];
   logic [TOTAL-1:0]      written;
   logic [CNT_W-1:0]      fill_cnt [5];

   logic                  wr_ok, rd_ok, wr_bad, rd_bad;
   logic [IDX_W-1:0]      wr_idx, rd_idx;
   logic [2:0]            wr_bank;
   logic [DATA_WIDTH-1:0] cdata_rd_q;
   logic                  rd_valid_q, err_q;

   always_comb begin
      wr_ok   = 1'b0;
      rd_ok   = 1'b0;
      wr_idx  = '0;
      rd_idx  = '0;
      wr_bank = bus.csel - 3'd1;
      if (depth_of(bus.csel) != 0) begin
         wr_ok = (32'(bus.caddr_wr) < depth_of(bus.csel));
         rd_ok = (32'(bus.caddr_rd) < depth_of(bus.csel));
      end
      wr_idx = IDX_W'(base_of(bus.csel) + 32'(bus.caddr_wr));
      rd_idx = IDX_W'(base_of(bus.csel) + 32'(bus.caddr_rd));
      wr_bad = bus.cwr && !wr_ok;
      rd_bad = bus.crd && !rd_ok;
   end

   // Storage has no reset; validity comes from the written bits.
   always_ff @(posedge clk) begin
      if (!reset && bus.cwr && wr_ok) mem[wr_idx] <= bus.cdata_wr;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         written    <= '0;
         for (int b = 0; b < 5; b++) fill_cnt[b] <= '0;
         cdata_rd_q <= '0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         rd_valid_q <= bus.crd;
         if (bus.crd) begin
            if (!rd_ok) cdata_rd_q <= '0;
`ifdef CONV_MEM_BYPASS_EN
            else if (bus.cwr && wr_ok && (wr_idx == rd_idx)) cdata_rd_q <= bus.cdata_wr;
`endif
            else if (written[rd_idx]) cdata_rd_q <= mem[rd_idx];
            else cdata_rd_q <= '0;
         end
         if (bus.cwr && wr_ok) begin
            written[wr_idx] <= 1'b1;
            if (!written[wr_idx]) fill_cnt[wr_bank] <= fill_cnt[wr_bank] + 1'b1;
         end
         if (wr_bad || rd_bad) err_q <= 1'b1;
      end
   end

   // Counters only step on first writes, so they saturate at depth and full stays set.
   always_comb begin
      for (int b = 0; b < 5; b++)
         bus.bank_full[b] = (32'(fill_cnt[b]) == depth_of(3'(b + 1)));
   end

   assign bus.cdata_rd = cdata_rd_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_conv_layer_mem.sv
// Directed bench for conv_layer_mem; expectations are hand-computed, build-dependent one via CONV_MEM_BYPASS_EN.
module tb_conv_layer_mem;
   localparam int DW = 20;
   localparam int AW = 12;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   conv_layer_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   conv_layer_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
   task automatic step(input logic rst, input logic [2:0] sel,
                       input logic wr, input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                       input logic rd, input logic [AW-1:0] raddr);
      @(negedge clk);
      reset        = rst;
      bus.csel     = sel;
      bus.cwr      = wr;
      bus.caddr_wr = waddr;
      bus.cdata_wr = wdata;
      bus.crd      = rd;
      bus.caddr_rd = raddr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 3'd0, 1'b0, '0, '0, 1'b0, '0);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [DW-1:0] exp_same;
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      bus.csel = '0; bus.cwr = 1'b0; bus.caddr_wr = '0; bus.cdata_wr = '0;
      bus.crd = 1'b0; bus.caddr_rd = '0;

      // Reset state
      step(1'b1, 3'd0, 1'b0, '0, '0, 1'b0, '0);
      step(1'b1, 3'd0, 1'b0, '0, '0, 1'b0, '0);
      check("rst_cdata_rd", 32'(bus.cdata_rd), 32'h0);
      check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
      check("rst_bank_full", 32'(bus.bank_full), 32'h0);
      check("rst_err", 32'(bus.err), 32'h0);

      // 1: write then read L0 kernel0
      step(1'b0, 3'd1, 1'b1, 12'h005, 20'h10000, 1'b0, '0);
      step(1'b0, 3'd1, 1'b0, '0, '0, 1'b1, 12'h005);
      check("t1_data", 32'(bus.cdata_rd), 32'h10000);
      check("t1_valid", 32'(bus.rd_valid), 32'h1);
      check("t1_err", 32'(bus.err), 32'h0);
      idle();
      check("t1_valid_drop", 32'(bus.rd_valid), 32'h0);
      check("t1_data_hold", 32'(bus.cdata_rd), 32'h10000);

      // 2: unwritten read, then out-of-range write
      step(1'b0, 3'd3, 1'b0, '0, '0, 1'b1, 12'h010);
      check("t2_unwritten", 32'(bus.cdata_rd), 32'h0);
      check("t2_valid", 32'(bus.rd_valid), 32'h1);
      check("t2_err0", 32'(bus.err), 32'h0);
      step(1'b0, 3'd3, 1'b1, 12'h400, 20'h0ABCD, 1'b0, '0);
      check("t2_err_oor", 32'(bus.err), 32'h1);
      step(1'b0, 3'd3, 1'b0, '0, '0, 1'b1, 12'h000);
      check("t2_rd0", 32'(bus.cdata_rd), 32'h0);
      check("t2_rd0_valid", 32'(bus.rd_valid), 32'h1);

      // 3: illegal select read, then reset clears err
      step(1'b0, 3'd1, 1'b0, '0, '0, 1'b1, 12'h005);
      check("t3_pre_data", 32'(bus.cdata_rd), 32'h10000);
      step(1'b0, 3'd6, 1'b0, '0, '0, 1'b1, 12'h005);
      check("t3_err", 32'(bus.err), 32'h1);
      check("t3_data", 32'(bus.cdata_rd), 32'h0);
      check("t3_valid", 32'(bus.rd_valid), 32'h1);
      step(1'b1, 3'd0, 1'b0, '0, '0, 1'b0, '0);
      check("t3_rst_err", 32'(bus.err), 32'h0);
      check("t3_rst_valid", 32'(bus.rd_valid), 32'h0);
      step(1'b0, 3'd1, 1'b0, '0, '0, 1'b1, 12'h005);
      check("t3_written_cleared", 32'(bus.cdata_rd), 32'h0);
      step(1'b0, 3'd7, 1'b1, 12'h001, 20'h1, 1'b0, '0);
      check("t3_err_wr_sel7", 32'(bus.err), 32'h1);
      step(1'b1, 3'd0, 1'b0, '0, '0, 1'b0, '0);

      // 4: fill L1 kernel1
      for (int a = 0; a < 1023; a++) step(1'b0, 3'd4, 1'b1, AW'(a), 20'h00001, 1'b0, '0);
      check("t4_full_1023", 32'(bus.bank_full), 32'h0);
      step(1'b0, 3'd4, 1'b1, 12'd0, 20'h00007, 1'b0, '0);
      check("t4_rewrite_not_full", 32'(bus.bank_full), 32'h0);
      step(1'b0, 3'd4, 1'b1, 12'd1023, 20'h00001, 1'b0, '0);
      check("t4_full_1024", 32'(bus.bank_full), 32'h08);
      step(1'b0, 3'd4, 1'b1, 12'd0, 20'h00001, 1'b0, '0);
      check("t4_full_rewrite", 32'(bus.bank_full), 32'h08);
      step(1'b0, 3'd4, 1'b0, '0, '0, 1'b1, 12'd1023);
      check("t4_last_data", 32'(bus.cdata_rd), 32'h00001);
      check("t4_err", 32'(bus.err), 32'h0);

      // 5: same-entry read/write collision in L2
      step(1'b0, 3'd5, 1'b1, 12'h7FF, 20'h00AAA, 1'b0, '0);
`ifdef CONV_MEM_BYPASS_EN
      exp_same = 20'h00BBB;
`else
      exp_same = 20'h00AAA;
`endif
      step(1'b0, 3'd5, 1'b1, 12'h7FF, 20'h00BBB, 1'b1, 12'h7FF);
      check("t5_collision", 32'(bus.cdata_rd), 32'(exp_same));
      step(1'b0, 3'd5, 1'b0, '0, '0, 1'b1, 12'h7FF);
      check("t5_after", 32'(bus.cdata_rd), 32'h00BBB);
      step(1'b0, 3'd5, 1'b1, 12'h010, 20'h00CCC, 1'b1, 12'h7FF);
      check("t5_diff_addr", 32'(bus.cdata_rd), 32'h00BBB);
      step(1'b0, 3'd5, 1'b0, '0, '0, 1'b1, 12'h010);
      check("t5_diff_wr", 32'(bus.cdata_rd), 32'h00CCC);
      check("t5_full_l2", 32'(bus.bank_full), 32'h08);

      // 6: strobes during reset are ignored
      step(1'b1, 3'd2, 1'b1, 12'h020, 20'h12345, 1'b1, 12'h020);
      check("t6_valid", 32'(bus.rd_valid), 32'h0);
      check("t6_full_cleared", 32'(bus.bank_full), 32'h0);
      idle();
      check("t6_valid_idle", 32'(bus.rd_valid), 32'h0);
      step(1'b0, 3'd2, 1'b0, '0, '0, 1'b1, 12'h020);
      check("t6_no_write", 32'(bus.cdata_rd), 32'h0);
      check("t6_err", 32'(bus.err), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
